// File: rtl/spi_sram_pkg.sv
// ==== spi_sram_pkg : state encoding and command constants for spi_sram_target ==== rev 1.0 ====
`default_nettype none

package spi_sram_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_WDATA  = 3'd3,
    S_RDATA  = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_RDMR   = 8'h05;
  localparam logic [7:0] CMD_WRMR   = 8'h01;
  localparam logic [7:0] MODE_RESET = 8'h40;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ==== spi_sync_edge : SPI pin synchronizers with serial-clock edge detect ==== rev 1.0 ====
`default_nettype none

module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n,
  output logic mosi
);

  logic [SYNC_STAGES-1:0] clk_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   clk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_q    <= '0;
      cs_q     <= '1;
      mosi_q   <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_q[0]  <= spi_clk;
      cs_q[0]   <= spi_cs_n;
      mosi_q[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_q[i]  <= clk_q[i-1];
        cs_q[i]   <= cs_q[i-1];
        mosi_q[i] <= mosi_q[i-1];
      end
      clk_prev <= clk_q[SYNC_STAGES-1];
    end
  end

  // mosi shares the clock's pipeline depth, so it is aligned with the detected rise
  assign sclk_rise = clk_q[SYNC_STAGES-1] & ~clk_prev;
  assign sclk_fall = ~clk_q[SYNC_STAGES-1] & clk_prev;
  assign cs_n      = cs_q[SYNC_STAGES-1];
  assign mosi      = mosi_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_sram_target.sv
// ==== spi_sram_target : SPI mode-0 byte SRAM; option macro SPI_SRAM_TARGET_MODE_REG_EN ==== rev 1.0 ====
`default_nettype none

module spi_sram_target #(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic busy,
  output logic cmd_err
);

  import spi_sram_pkg::*;

  logic              sclk_rise, sclk_fall, cs_n_s, mosi_s;
  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [6:0]        rx_sh, rx_sh_n;
  logic [7:0]        tx_sh, tx_sh_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              is_write, is_write_n;
  logic              miso_r, miso_n;
  logic              cmd_err_r, cmd_err_n;
  logic              mem_we;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] addr_inc, addr_shift;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
  logic              reg_sel, reg_sel_n;
  logic [7:0]        mode_reg, mode_reg_n;
`endif

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .spi_clk   (spi_clk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_n      (cs_n_s),
    .mosi      (mosi_s)
  );

  assign rx_byte    = {rx_sh, mosi_s};
  assign addr_inc   = addr + ADDR_W'(1);
  // upper address bits simply fall off the top of the shifter
  assign addr_shift = ADDR_W'({addr, mosi_s});

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      addr      <= '0;
      is_write  <= 1'b0;
      miso_r    <= 1'b0;
      cmd_err_r <= 1'b0;
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
      reg_sel   <= 1'b0;
      mode_reg  <= MODE_RESET;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rx_sh     <= rx_sh_n;
      tx_sh     <= tx_sh_n;
      addr      <= addr_n;
      is_write  <= is_write_n;
      miso_r    <= miso_n;
      cmd_err_r <= cmd_err_n;
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
      reg_sel   <= reg_sel_n;
      mode_reg  <= mode_reg_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rx_sh_n    = rx_sh;
    tx_sh_n    = tx_sh;
    addr_n     = addr;
    is_write_n = is_write;
    miso_n     = miso_r;
    cmd_err_n  = 1'b0;
    mem_we     = 1'b0;
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
    reg_sel_n  = reg_sel;
    mode_reg_n = mode_reg;
`endif
    if (cs_n_s) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        // serial-clock edges are ignored here, so a rise coincident with cs_n falling is not counted
        S_IDLE: begin
          state_n    = S_CMD;
          cnt_n      = '0;
          is_write_n = 1'b0;
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
          reg_sel_n  = 1'b0;
`endif
        end
        S_CMD: if (sclk_rise) begin
          rx_sh_n = rx_byte[6:0];
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n = '0;
            case (rx_byte)
              CMD_READ:  begin state_n = S_ADDR; is_write_n = 1'b0; end
              CMD_WRITE: begin state_n = S_ADDR; is_write_n = 1'b1; end
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
              CMD_RDMR:  begin state_n = S_RDATA; reg_sel_n = 1'b1; tx_sh_n = mode_reg; end
              CMD_WRMR:  begin state_n = S_WDATA; reg_sel_n = 1'b1; end
`endif
              default:   begin state_n = S_IGNORE; cmd_err_n = 1'b1; end
            endcase
          end
        end
        S_ADDR: if (sclk_rise) begin
          addr_n = addr_shift;
          cnt_n  = cnt + 4'd1;
          if (cnt == 4'd15) begin
            cnt_n   = '0;
            state_n = is_write ? S_WDATA : S_RDATA;
            tx_sh_n = mem[addr_shift];
          end
        end
        S_WDATA: if (sclk_rise) begin
          rx_sh_n = rx_byte[6:0];
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n = '0;
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
            if (reg_sel) begin
              mode_reg_n = rx_byte;
            end else begin
              mem_we = 1'b1;
              addr_n = addr_inc;
            end
`else
            mem_we = 1'b1;
            addr_n = addr_inc;
`endif
          end
        end
        S_RDATA: if (sclk_fall) begin
          miso_n = tx_sh[7];
          cnt_n  = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n = '0;
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
            if (reg_sel) begin
              tx_sh_n = mode_reg;
            end else begin
              tx_sh_n = mem[addr_inc];
              addr_n  = addr_inc;
            end
`else
            tx_sh_n = mem[addr_inc];
            addr_n  = addr_inc;
`endif
          end else begin
            tx_sh_n = {tx_sh[6:0], 1'b0};
          end
        end
        S_IGNORE: state_n = S_IGNORE;
        default:  state_n = S_IDLE;
      endcase
    end
    if (state_n != S_RDATA) miso_n = 1'b0;
  end

  // memory is deliberately outside reset so contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[addr] <= rx_byte;
  end

  assign spi_miso = miso_r;
  assign busy     = (state != S_IDLE);
  assign cmd_err  = cmd_err_r;

endmodule

`default_nettype wire

// File: doc/spi_sram_target.md
SPI_SRAM_TARGET -- requirements
Module: spi_sram_target

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning log2 of internal byte-memory depth (256 bytes).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning input synchronizer depth for spi_clk, spi_cs_n and spi_mosi.
REQ-003 SHALL have port clk  input  1  system clock; one clock domain; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port spi_clk  input  1  SPI serial clock from initiator (mode 0), asynchronous to clk.
REQ-006 SHALL have port spi_cs_n  input  1  chip select, active-low.
REQ-007 SHALL have port spi_mosi  input  1  serial data in, MSB first.
REQ-008 SHALL have port spi_miso  output  1  serial data out, MSB first.
REQ-009 SHALL have port busy  output  1  high while a transaction is active (synced cs_n low).
REQ-010 SHALL have port cmd_err  output  1  one-clk pulse when an unsupported command byte completes.

Function
REQ-011 SHALL pass spi_clk, spi_cs_n, spi_mosi through SYNC_STAGES flops; all decoding uses synced copies; clk >= 4x spi_clk is required.
REQ-012 SHALL detect spi_clk rising edge (sample mosi) and falling edge (update miso) from synced-clock edge detect.
REQ-013 SHALL implement states S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_IGNORE.
REQ-014 S_IDLE -> S_CMD on synced cs_n falling; bit counter cleared.
REQ-015 S_CMD: shift 8 bits; on 8th rising edge: 0x03 -> S_ADDR(read), 0x02 -> S_ADDR(write), else cmd_err pulse and -> S_IGNORE.
REQ-016 S_ADDR: shift 16 address bits; only the low ADDR_W bits are used, upper bits ignored; on 16th rising edge -> S_RDATA or S_WDATA.
REQ-017 S_RDATA: memory byte at current address loaded into output shifter on entry; MSB driven on spi_miso at the next falling edge, subsequent bits on each falling edge; after 8 bits, address increments and next byte loads, with no gap.
REQ-018 S_WDATA: on every 8th data rising edge, assembled byte written to memory at current address, then address increments.
REQ-019 Address increment SHALL wrap modulo 2^ADDR_W (sequential mode).
REQ-020 S_IGNORE: no memory access, spi_miso held 0 until cs_n high.
REQ-021 Synced cs_n rising in any state SHALL return to S_IDLE within 1 clk; a partial write byte is discarded; a partial read byte is dropped.
REQ-022 spi_miso SHALL be 0 outside S_RDATA (no tri-state; top level gates with cs_n).
REQ-023 spi_clk edges while cs_n high SHALL be ignored.
REQ-024 cs_n falling and spi_clk rising in the same synced clk: cs_n takes priority; the clock edge is not counted.

Reset
REQ-025 On rst: state S_IDLE, counters 0, address 0, spi_miso 0, busy 0, cmd_err 0, synchronizers loaded with idle values (cs_n=1, clk=0, mosi=0).
REQ-026 Memory contents SHALL NOT be cleared by rst; rst mid-transaction aborts it with no write of a partial byte.

Configuration
REQ-027 Macro SPI_SRAM_TARGET_MODE_REG_EN: when defined, command 0x05 (RDMR) returns 8-bit mode register (reset 8'h40) on spi_miso, repeated until cs_n high, and 0x01 (WRMR) writes the next byte to it; when undefined, 0x05/0x01 are unsupported (cmd_err, S_IGNORE).

Structure
REQ-028 Shared package spi_sram_pkg SHALL hold the state enum and command constants (CMD_READ 8'h03, CMD_WRITE 8'h02, CMD_RDMR 8'h05, CMD_WRMR 8'h01, MODE_RESET 8'h40).
REQ-029 Sub-module spi_sync_edge SHALL provide the synchronizer plus rise/fall edge detection; memory is an inferred array within spi_sram_target.

Verification
REQ-030 Write 02 0010 DEADBEEF, then read 03 0010 + 32 clocks -> miso returns DEADBEEF MSB first.
REQ-031 Write 02 00FF 11 22 (ADDR_W=8) -> byte 0xFF=11, byte 0x00=22 (wrap); read from 00FF returns 11 22.
REQ-032 Command 0xAB -> cmd_err single-clk pulse, miso 0, memory unchanged; next transaction with 0x03 works normally.
REQ-033 Write 02 0020 + 12 bits, cs_n high -> only byte 0x20 written, 0x21 unchanged.
REQ-034 rst asserted during S_WDATA bit 5 -> busy 0, state S_IDLE, target byte unchanged, prior memory preserved.
REQ-035 With SPI_SRAM_TARGET_MODE_REG_EN: 05 -> 40; 01 00 then 05 -> 00; without macro: 05 -> cmd_err.
